// File: rtl/fetch_pkg.sv
// Shared types and constants for the Wishbone instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_S  = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
  localparam logic [2:0]  CTI_CLASSIC  = 3'b000;

endpackage

// File: rtl/fetch_stage_wb.sv
// Instruction fetch stage: Wishbone classic read-only master with jump redirect.
// Build option FETCH_ERR_NOP_EN: a bus error in FETCH delivers a NOP instead of retrying.
//
// state    | meaning
// RESET_S  | bus idle, waiting for first cycle after reset
// FETCH    | sequential fetch; bus idle for one cycle after a retry
// REDIRECT | jump pending, waiting for the outstanding cycle to end
module fetch_stage_wb
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ACK_I,
  input  logic        ERR_I,
  input  logic        RTY_I,
  output logic        STB_O,
  output logic        CYC_O,
  output logic [31:0] ADR_O,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        WE_O,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        stall_o,
  input  logic [31:0] jmp_addr_i,
  input  logic        jmp_i
);

  fetch_state_t state_q, state_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  ins_q, ins_d;
  logic [31:0]  pc_q, pc_d;
  logic         stb_q, stb_d;
  logic         stall_q, stall_d;
  logic [31:0]  jmp_tgt;
  logic [31:0]  redir;
  logic         ack_like;
  logic         retry;

  assign jmp_tgt = {jmp_addr_i[31:2], 2'b00};

`ifdef FETCH_ERR_NOP_EN
  assign ack_like = ACK_I | ERR_I;
  assign retry    = ~ACK_I & ~ERR_I & RTY_I;
`else
  assign ack_like = ACK_I;
  assign retry    = ~ACK_I & (RTY_I | ERR_I);
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    tgt_d   = tgt_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    stb_d   = stb_q;
    stall_d = 1'b1;
    redir   = jmp_i ? jmp_tgt : tgt_q;
    case (state_q)
      RESET_S: begin
        state_d = FETCH;
        stb_d   = 1'b1;
      end
      FETCH: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          if (jmp_i) adr_d = jmp_tgt;
        end else if (ack_like) begin
          if (jmp_i) begin
            adr_d = jmp_tgt;
          end else begin
            ins_d   = ACK_I ? DAT_I : NOP_INSN;
            pc_d    = adr_q;
            stall_d = 1'b0;
            adr_d   = adr_q + 32'd4;
          end
        end else if (retry) begin
          stb_d = 1'b0;
          if (jmp_i) adr_d = jmp_tgt;
        end else if (jmp_i) begin
          // Address must not change mid-cycle; park the target until the slave responds.
          tgt_d   = jmp_tgt;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (ACK_I || ERR_I) begin
          adr_d   = redir;
          state_d = FETCH;
        end else if (RTY_I) begin
          adr_d   = redir;
          stb_d   = 1'b0;
          state_d = FETCH;
        end else begin
          tgt_d = redir;
        end
      end
      default: state_d = RESET_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_S;
      adr_q   <= RESET_PC;
      tgt_q   <= RESET_PC;
      ins_q   <= 32'h0;
      pc_q    <= 32'h0;
      stb_q   <= 1'b0;
      stall_q <= 1'b1;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      tgt_q   <= tgt_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      stb_q   <= stb_d;
      stall_q <= stall_d;
    end
  end

  assign STB_O   = stb_q;
  assign CYC_O   = stb_q;
  assign ADR_O   = adr_q;
  assign DAT_O   = 32'h0;
  assign WE_O    = 1'b0;
  assign ins_o   = ins_q;
  assign pc_o    = pc_q;
  assign stall_o = stall_q;

endmodule

// File: tb/tb_fetch_stage_wb.sv
// Directed bench for fetch_stage_wb with a simple memory slave driven by the stimulus.
module tb_fetch_stage_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ACK_I, ERR_I, RTY_I;
  logic        STB_O, CYC_O, WE_O;
  logic [31:0] ADR_O, DAT_I, DAT_O;
  logic [31:0] ins_o, pc_o;
  logic        stall_o;
  logic [31:0] jmp_addr_i;
  logic        jmp_i;

  logic [31:0] mem [256];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign DAT_I = mem[ADR_O[9:2]];

  fetch_stage_wb dut (
    .clk(clk), .rst(rst),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I),
    .STB_O(STB_O), .CYC_O(CYC_O), .ADR_O(ADR_O),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .WE_O(WE_O),
    .ins_o(ins_o), .pc_o(pc_o), .stall_o(stall_o),
    .jmp_addr_i(jmp_addr_i), .jmp_i(jmp_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic stall, input logic [31:0] adr);
    chk({tag, ".ins"}, ins_o, ins);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".stall"}, {31'h0, stall_o}, {31'h0, stall});
    chk({tag, ".adr"}, ADR_O, adr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h11;
    mem[1]   = 32'h22;
    mem[2]   = 32'h33;
    mem[3]   = 32'h44;
    mem[16]  = 32'h0000_0A16;
    mem[17]  = 32'h0000_DEAD;
    mem[32]  = 32'h0000_0800;
    mem[128] = 32'h0000_2000;
    mem[255] = 32'hFFFF_0255;
    rst = 1'b1; ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    jmp_i = 1'b0; jmp_addr_i = 32'h0;

    // reset held for 5 cycles, jumps ignored
    for (int i = 0; i < 5; i++) begin
      jmp_i = (i == 2); jmp_addr_i = 32'h300;
      tick();
      chk("rst.stb", {31'h0, STB_O}, 32'h0);
      chk("rst.cyc", {31'h0, CYC_O}, 32'h0);
      chk("rst.we", {31'h0, WE_O}, 32'h0);
      chk("rst.dat_o", DAT_O, 32'h0);
      chk_out("rst", 32'h0, 32'h0, 1'b1, 32'h0);
    end
    jmp_i = 1'b0;

    // release: first request one cycle later
    rst = 1'b0;
    tick();
    chk("rel.stb", {31'h0, STB_O}, 32'h1);
    chk("rel.cyc", {31'h0, CYC_O}, 32'h1);
    chk_out("rel", 32'h0, 32'h0, 1'b1, 32'h0);

    // sequential fetch of 4 words
    ACK_I = 1'b1;
    tick(); chk_out("seq0", 32'h11, 32'h0, 1'b0, 32'h4);
    tick(); chk_out("seq1", 32'h22, 32'h4, 1'b0, 32'h8);
    tick(); chk_out("seq2", 32'h33, 32'h8, 1'b0, 32'hC);
    tick(); chk_out("seq3", 32'h44, 32'hC, 1'b0, 32'h10);
    ACK_I = 1'b0;
    tick(); chk_out("hold", 32'h44, 32'hC, 1'b1, 32'h10);

    // restart from reset, jump on same edge as ack of 0x8
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    ACK_I = 1'b1;
    tick(); tick();
    chk_out("pre_j", 32'h22, 32'h4, 1'b0, 32'h8);
    jmp_i = 1'b1; jmp_addr_i = 32'h40;
    tick(); chk_out("jack", 32'h22, 32'h4, 1'b1, 32'h40);
    jmp_i = 1'b0;
    tick(); chk_out("jack_t", 32'h0A16, 32'h40, 1'b0, 32'h44);

    // jump while ack withheld; late ack data discarded
    ACK_I = 1'b0; jmp_i = 1'b1; jmp_addr_i = 32'h80;
    tick(); chk_out("jwait", 32'h0A16, 32'h40, 1'b1, 32'h44);
    jmp_i = 1'b0;
    tick(); chk_out("jwait2", 32'h0A16, 32'h40, 1'b1, 32'h44);
    ACK_I = 1'b1;
    tick(); chk_out("jdisc", 32'h0A16, 32'h40, 1'b1, 32'h80);
    tick(); chk_out("jdisc_t", 32'h0800, 32'h80, 1'b0, 32'h84);

    // two jumps before ack: last one wins
    ACK_I = 1'b0; jmp_i = 1'b1; jmp_addr_i = 32'h100;
    tick(); chk_out("j2a", 32'h0800, 32'h80, 1'b1, 32'h84);
    jmp_addr_i = 32'h200;
    tick(); chk_out("j2b", 32'h0800, 32'h80, 1'b1, 32'h84);
    jmp_i = 1'b0; ACK_I = 1'b1;
    tick(); chk_out("j2c", 32'h0800, 32'h80, 1'b1, 32'h200);
    tick(); chk_out("j2t", 32'h2000, 32'h200, 1'b0, 32'h204);

    // unaligned target is masked; address wraps past 0xFFFFFFFC
    jmp_i = 1'b1; jmp_addr_i = 32'hFFFF_FFFF;
    tick(); chk_out("wrapj", 32'h2000, 32'h200, 1'b1, 32'hFFFF_FFFC);
    jmp_i = 1'b0;
    tick(); chk_out("wrap", 32'hFFFF_0255, 32'hFFFF_FFFC, 1'b0, 32'h0);

    // reset mid-transaction releases the bus
    rst = 1'b1;
    tick();
    chk("midrst.stb", {31'h0, STB_O}, 32'h0);
    chk_out("midrst", 32'h0, 32'h0, 1'b1, 32'h0);
    rst = 1'b0; ACK_I = 1'b0;
    tick();
    ACK_I = 1'b1;
    tick(); chk_out("r0", 32'h11, 32'h0, 1'b0, 32'h4);

    // retry at 0x4: one idle cycle then reissue
    ACK_I = 1'b0; RTY_I = 1'b1;
    tick();
    chk("rty.stb", {31'h0, STB_O}, 32'h0);
    chk_out("rty", 32'h11, 32'h0, 1'b1, 32'h4);
    RTY_I = 1'b0;
    tick();
    chk("rty.reissue", {31'h0, STB_O}, 32'h1);
    chk_out("rty2", 32'h11, 32'h0, 1'b1, 32'h4);
    ACK_I = 1'b1; RTY_I = 1'b1;
    tick(); chk_out("ackwin", 32'h22, 32'h4, 1'b0, 32'h8);

    // bus error at 0x8
    ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b1;
    tick();
`ifdef FETCH_ERR_NOP_EN
    chk_out("errnop", 32'h13, 32'h8, 1'b0, 32'hC);
    chk("errnop.stb", {31'h0, STB_O}, 32'h1);
    ERR_I = 1'b0;
`else
    chk("err.stb", {31'h0, STB_O}, 32'h0);
    chk_out("err", 32'h22, 32'h4, 1'b1, 32'h8);
    ERR_I = 1'b0;
    tick();
    chk("err.reissue", {31'h0, STB_O}, 32'h1);
    ACK_I = 1'b1;
    tick(); chk_out("err_t", 32'h33, 32'h8, 1'b0, 32'hC);
    ACK_I = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage_wb.md
Name: fetch_stage_wb

Overview:
- Instruction-fetch stage of the in-order RISC-V core.
- Acts as a Wishbone classic read-only master that fetches 32-bit words sequentially from instruction memory, starting at a reset PC.
- Presents each instruction with its PC to decode, plus a stall flag.
- Accepts jump redirects from later stages; benched against the single-port `ram` Wishbone slave.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetch after reset (word aligned)
NOP_INSN, 32'h0000_0013, instruction emitted on bus error (addi x0,x0,0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ACK_I  in  1  Wishbone ack from slave
ERR_I  in  1  Wishbone error from slave
RTY_I  in  1  Wishbone retry from slave
STB_O  out  1  Wishbone strobe
CYC_O  out  1  Wishbone cycle
ADR_O  out  32  Wishbone byte address (bits[1:0] always 0)
DAT_I  in  32  Wishbone read data
DAT_O  out  32  Wishbone write data, tied 0
WE_O  out  1  Wishbone write enable, tied 0
ins_o  out  32  fetched instruction
pc_o  out  32  address of ins_o
stall_o  out  1  1 = ins_o/pc_o not valid this cycle
jmp_addr_i  in  32  jump target
jmp_i  in  1  jump request, one-cycle pulse

Behaviour:
- Reset (rst high at edge):
  - STB_O=CYC_O=0, ADR_O=RESET_PC, ins_o=0, pc_o=0, stall_o=1.
  - Jump pending flag cleared; jmp_i ignored.
- All outputs are registered.
- States: RESET_S, FETCH, REDIRECT.
- First edge with rst low: go to FETCH, CYC_O=STB_O=1, ADR_O=pc. First request is visible one cycle after reset release.
- FETCH, edge with ACK_I=1, no jump/pending:
  - ins_o<=DAT_I, pc_o<=ADR_O, stall_o<=0, ADR_O<=ADR_O+4.
  - STB/CYC stay high (back-to-back classic cycles), so throughput is one instruction per ack.
- Any edge without a valid ack: stall_o<=1. stall_o is a one-cycle-per-instruction valid pulse, inverted.
- ADR_O increments mod 2^32; 32'hFFFF_FFFC wraps to 0.
- RTY_I=1 (without ACK): same address re-presented; STB/CYC deassert for one cycle, then reissue; stall_o=1.
- ERR_I=1: see Optional Feature.
- Simultaneous ACK_I with ERR_I/RTY_I: ACK_I wins.
- jmp_i=1 at an edge:
  - If ACK_I is also 1 that edge: returned data discarded (stall_o stays 1), ADR_O<=jmp_addr_i & ~3.
  - Otherwise: enter REDIRECT; store target, keep ADR_O unchanged (no mid-cycle address change).
- REDIRECT:
  - On ACK/ERR: data discarded, ADR_O<=stored target, back to FETCH.
  - A further jmp_i overwrites the stored target (last jump wins).
  - RTY in REDIRECT: go straight to the target (reissue there).
- pc_o/ins_o hold their last value while stall_o=1.
- Reset mid-transaction: bus released on that edge; no partial data delivered.

Optional Feature:
Macro FETCH_ERR_NOP_EN.
- Defined: ERR_I in FETCH completes the instruction: ins_o<=NOP_INSN, pc_o<=ADR_O, stall_o<=0, PC advances by 4.
- Undefined: ERR_I treated exactly like RTY_I (retry same address, stall_o=1).

Decomposition:
- Package fetch_pkg holds: the state enum (RESET_S, FETCH, REDIRECT), NOP_INSN default, RESET_PC default, and the Wishbone CTI classic constant 3'b000.
- No sub-module is needed; a single module is natural.
- The `ram` slave is a separate block, used as the bench memory model.

Test Plan:
- Reset release with ram holding words 0..3 = 11,22,33,44 → ins_o/pc_o sequence (11,0),(22,4),(33,8),(44,12); stall_o low exactly one cycle per ack; ADR_O steps 0,4,8,C.
- During rst high for 5 cycles → STB_O=CYC_O=0, stall_o=1, WE_O=0, DAT_O=0.
- jmp_i with jmp_addr_i=0x40 on the same edge as ack of 0x8 → word at 0x8 never shown; next valid pc_o=0x40.
- jmp_i to 0x80 while ack withheld, then ack with data 0xDEAD → 0xDEAD discarded; next ADR_O=0x80.
- Two jumps (0x100 then 0x200) before ack → fetch goes to 0x200.
- Slave asserts RTY_I once at 0x4 → 0x4 reissued after one idle cycle. Then ERR_I at 0x8: with FETCH_ERR_NOP_EN, ins_o=0x00000013 and pc_o=0x8; without it, 0x8 is retried.
